// File: rtl/ter_pkg.sv
// Shared trit encodings and inverter mode codes for the ternary inverter pipeline.
package ter_pkg;

  localparam logic [1:0] T0   = 2'b00;
  localparam logic [1:0] T1   = 2'b01;
  localparam logic [1:0] T2   = 2'b10;
  localparam logic [1:0] TILL = 2'b11;

  typedef enum logic [1:0] {
    STI = 2'b00,
    PTI = 2'b01,
    NTI = 2'b10,
    BYP = 2'b11
  } ter_mode_e;

endpackage

// File: rtl/ter_trit_xform.sv
// Combinational single-trit inverter: standard, positive, negative or bypass.
module ter_trit_xform
  import ter_pkg::*;
(
  input  logic [1:0] trit,
  input  ter_mode_e  mode,
  output logic [1:0] result,
  output logic       illegal
);

  always_comb begin
    result  = T0;
    illegal = 1'b0;
    // Illegal code 11 collapses to 0 in every mode and is flagged.
    if (trit == TILL) begin
      illegal = 1'b1;
    end else begin
      case (mode)
        STI:     result = (trit == T0) ? T2 : ((trit == T2) ? T0 : T1);
        PTI:     result = (trit == T2) ? T0 : T2;
        NTI:     result = (trit == T0) ? T2 : T0;
        default: result = trit;
      endcase
    end
  end

endmodule

// File: rtl/ter_inv_pipe.sv
// Ternary inverter pipeline: per-trit transform on accept, DEPTH-entry output FIFO,
// saturating error counter with sticky flag.
module ter_inv_pipe
  import ter_pkg::*;
#(
  parameter int NTRITS = 4,
  parameter int DEPTH  = 2,
  parameter int CNTW   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*NTRITS-1:0] in_data,
  input  logic [1:0]          in_mode,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*NTRITS-1:0] out_data,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                err_clr,
  output logic                err_sticky,
  output logic [CNTW-1:0]     err_cnt
);

  localparam int W  = 2 * NTRITS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  logic [W-1:0]      xf_data;
  logic [NTRITS-1:0] xf_ill;

  for (genvar i = 0; i < NTRITS; i++) begin : g_trit
    ter_trit_xform u_xf (
      .trit    (in_data[2*i +: 2]),
      .mode    (ter_mode_e'(in_mode)),
      .result  (xf_data[2*i +: 2]),
      .illegal (xf_ill[i])
    );
  end

  // Handshake: a word moves on any edge where valid and ready are both high;
  // the producer holds data stable until then, and ready never depends on valid.
  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          rdy_q;
  logic          push, pop, err_word;
  logic [W:0]    head;

  assign push     = in_valid & rdy_q;
  assign pop      = out_valid & out_ready;
  assign err_word = push & (|xf_ill);
  assign head     = mem[rd_ptr];

  assign in_ready  = rdy_q;
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head[W-1:0] : '0;
  assign out_err   = out_valid & head[W];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {|xf_ill, xf_data};
  end

  // Ready is registered from next occupancy, so out_ready never reaches in_ready
  // combinationally and a pop from full frees a slot only on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      rdy_q <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_cnt    <= err_word ? CNTW'(1) : '0;
      err_sticky <= err_word;
    end else if (err_word) begin
      if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ter_inv_pipe.sv
// Directed and randomised checks of ter_inv_pipe with a queue scoreboard on the output port.
module tb_ter_inv_pipe;
  import ter_pkg::*;

  localparam int NTRITS = 4;
  localparam int DEPTH  = 2;
  localparam int CNTW   = 2;
  localparam int W      = 2 * NTRITS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic [1:0]      in_mode = 2'b00;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_err;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            err_clr = 1'b0;
  logic            err_sticky;
  logic [CNTW-1:0] err_cnt;

  int vectors = 0;
  int errors  = 0;
  logic [W:0] exp_q[$];
  logic [W:0] mon_e;

  ter_inv_pipe #(.NTRITS(NTRITS), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model written straight from the trit truth tables.
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    logic         e;
    logic [1:0]   x, y;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < NTRITS; i++) begin
      x = d[2*i +: 2];
      y = 2'd0;
      if (x == 2'b11) e = 1'b1;
      else begin
        case (m)
          2'b00:   y = 2'd2 - x;
          2'b01:   y = (x == 2'd2) ? 2'd0 : 2'd2;
          2'b10:   y = (x == 2'd0) ? 2'd2 : 2'd0;
          default: y = x;
        endcase
      end
      r[2*i +: 2] = y;
    end
    return {e, r};
  endfunction

  // Scoreboard: compare the head word on every cycle it is consumed.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", {23'd0, out_err, out_data}, 32'hdead);
      else begin
        mon_e = exp_q.pop_front();
        check("out_word", {23'd0, out_err, out_data}, {23'd0, mon_e});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic [1:0] m, input logic [W:0] exp);
    int n = 0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [1:0]   m;
    logic [W-1:0] hold_data;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_sticky", err_sticky, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // STI with one-cycle latency
    send(8'b10_01_00_10, STI, {1'b0, 8'b00_01_10_00});
    check("latency_valid", out_valid, 1);
    check("sti_data_now", out_data, 8'b00_01_10_00);
    check("sti_err_now", out_err, 0);
    wait_drain();

    // PTI then NTI on trits {0,1,2,0}
    send(8'b00_10_01_00, PTI, {1'b0, 8'b10_00_10_10});
    send(8'b00_10_01_00, NTI, {1'b0, 8'b10_00_00_10});
    wait_drain();

    // BYPASS with an illegal trit
    send(8'b01_11_10_00, BYP, {1'b1, 8'b01_00_10_00});
    check("byp_err_cnt", err_cnt, 1);
    check("byp_err_sticky", err_sticky, 1);
    wait_drain();

    // Backpressure: fill, hold, then drain in order and take word 3
    out_ready = 1'b0;
    send(8'b00_00_00_01, STI, {1'b0, 8'b10_10_10_01});
    send(8'b00_00_10_00, STI, {1'b0, 8'b10_10_00_10});
    check("full_in_ready", in_ready, 0);
    hold_data = out_data;
    repeat (3) @(posedge clk);
    #1;
    check("full_hold_in_ready", in_ready, 0);
    check("hold_data_stable", out_data, hold_data);
    check("hold_head", out_data, 8'b10_10_10_01);
    out_ready = 1'b1;
    @(negedge clk);
    check("pop_full_no_ready", in_ready, 0);
    send(8'b00_10_00_00, BYP, {1'b0, 8'b00_10_00_00});
    wait_drain();

    // Saturating counter and clear coincident with an erroneous word
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("clr_cnt", err_cnt, 0);
    check("clr_sticky", err_sticky, 0);
    for (int k = 1; k <= 5; k++) begin
      d = 8'($urandom_range(0, 255)) | 8'b0000_0011;
      m = 2'($urandom_range(0, 3));
      send(d, m, model(d, m));
      check("sat_cnt", err_cnt, (k > 3) ? 3 : k);
    end
    check("sat_sticky", err_sticky, 1);
    err_clr = 1'b1;
    send(8'b11_00_00_00, STI, {1'b1, 8'b00_10_10_10});
    err_clr = 1'b0;
    check("clr_with_err_cnt", err_cnt, 1);
    check("clr_with_err_sticky", err_sticky, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("clr_alone_cnt", err_cnt, 0);
    wait_drain();

    // Random words with random backpressure
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom_range(0, 255));
      m = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      send(d, m, model(d, m));
    end
    out_ready = 1'b1;
    wait_drain();

    // Reset mid-transfer with two words buffered
    out_ready = 1'b0;
    send(8'b11_11_00_00, STI, model(8'b11_11_00_00, STI));
    send(8'b00_00_11_01, NTI, model(8'b00_00_11_01, NTI));
    check("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("after_rst_in_ready", in_ready, 1);
    check("after_rst_empty", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("after_rst_still_empty", out_valid, 0);
    send(8'b10_10_10_10, PTI, {1'b0, 8'b00_00_00_00});
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
